rtc_bus_sequencer: RTL

Bus sequencer and arbiter for the shared multiplexed address/data RTC bus. It grants the bus to either the read machine or the write machine. For each bus transaction it generates the DIR / DAT / cambio_estado phase pulses the owner machine steps on, and drives the physical strobes (CS_n, A_D, RD_n, WR_n, AD bus). It sits between the main control machine and the RTC pins.

---
 rtl/rtc_bus_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_sequencer.sv
// Arbiter and strobe sequencer for the multiplexed address/data RTC bus.
// Grants the bus to the read or write machine and paces each A0..NX transaction.
module rtc_bus_sequencer #(
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_GAP   = 2,
  parameter int unsigned T_OUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_lect,
  input  logic       req_escr,
  input  logic       E_Lect,
  input  logic       E_Escr,
  input  logic       Term_Lect,
  input  logic       Term_Escr,
  input  logic [7:0] Dir_L,
  input  logic [7:0] Dir_E,
  output logic       Lectura,
  output logic       Escritura,
  output logic       DIR,
  output logic       DAT,
  output logic       cambio_estado,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       busy,
  output logic       owner,
  output logic       err_to
);

  typedef enum logic [3:0] {IDLE, GRANT, A0, AW, AH, D0, DS, DH, NX, WT} state_t;

  typedef struct packed {
    logic lect;
    logic escr;
    logic dir;
    logic dat;
    logic cambio;
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic a_d;
    logic ad_oe;
    logic busy;
    logic err_to;
  } outs_t;

  localparam outs_t OUTS_RST = '{lect: 1'b0, escr: 1'b0, dir: 1'b0, dat: 1'b0,
                                 cambio: 1'b0, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                 a_d: 1'b0, ad_oe: 1'b0, busy: 1'b0, err_to: 1'b0};

  localparam logic [3:0] PULSE_LAST = 4'(T_PULSE - 1);
  localparam logic [3:0] GAP_LAST   = 4'(T_GAP - 1);
  localparam logic [7:0] WD_LAST    = 8'(T_OUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  wd_q, wd_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        timeout;
  outs_t       outs_q, outs_d;

  logic own_e, own_term;
  assign own_e    = owner_q ? E_Escr : E_Lect;
  assign own_term = owner_q ? Term_Escr : Term_Lect;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    owner_d = owner_q;
    last_d  = last_q;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: if (req_lect || req_escr) begin
        owner_d = (req_lect && req_escr) ? ~last_q : req_escr;
        last_d  = (req_lect && req_escr) ? ~last_q : req_escr;
        state_d = GRANT;
      end
      GRANT: begin
        state_d = WT;
        wd_d    = '0;
      end
      // Term outranks E; the watchdog only advances while the owner is silent.
      WT: if (own_term) begin
        state_d = IDLE;
      end else if (own_e) begin
        state_d = A0;
        wd_d    = '0;
      end else if (wd_q == WD_LAST) begin
        state_d = IDLE;
        wd_d    = '0;
        timeout = 1'b1;
      end else begin
        wd_d = wd_q + 8'd1;
      end
      A0: begin
        state_d = AW;
        cnt_d   = '0;
      end
      AW: if (cnt_q == PULSE_LAST) begin
        state_d = AH;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 4'd1;
      AH: if (cnt_q == GAP_LAST) begin
        state_d = D0;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 4'd1;
      D0: begin
        state_d = DS;
        cnt_d   = '0;
      end
      DS: if (cnt_q == PULSE_LAST) begin
        state_d = DH;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 4'd1;
      DH: if (cnt_q == GAP_LAST) begin
        state_d = NX;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 4'd1;
      NX: begin
        state_d = own_term ? IDLE : WT;
        wd_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with it.
  always_comb begin
    outs_d        = OUTS_RST;
    outs_d.busy   = (state_d != IDLE);
    outs_d.err_to = timeout;
    unique case (state_d)
      GRANT: begin
        outs_d.lect = ~owner_d;
        outs_d.escr = owner_d;
      end
      A0: begin
        outs_d.dir   = 1'b1;
        outs_d.cs_n  = 1'b0;
        outs_d.ad_oe = 1'b1;
      end
      AW: begin
        outs_d.cs_n  = 1'b0;
        outs_d.wr_n  = 1'b0;
        outs_d.ad_oe = 1'b1;
      end
      AH: outs_d.ad_oe = 1'b1;
      D0: begin
        outs_d.cs_n  = 1'b0;
        outs_d.a_d   = 1'b1;
        outs_d.ad_oe = owner_d;
      end
      DS: begin
        outs_d.cs_n  = 1'b0;
        outs_d.a_d   = 1'b1;
        outs_d.ad_oe = owner_d;
        outs_d.rd_n  = owner_d;
        outs_d.wr_n  = ~owner_d;
        outs_d.dat   = (cnt_d == PULSE_LAST);
      end
      DH: outs_d.a_d = 1'b1;
      NX: outs_d.cambio = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      outs_q  <= OUTS_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      outs_q  <= outs_d;
    end
  end

  assign Lectura       = outs_q.lect;
  assign Escritura     = outs_q.escr;
  assign DIR           = outs_q.dir;
  assign DAT           = outs_q.dat;
  assign cambio_estado = outs_q.cambio;
  assign CS_n          = outs_q.cs_n;
  assign RD_n          = outs_q.rd_n;
  assign WR_n          = outs_q.wr_n;
  assign A_D           = outs_q.a_d;
  assign AD_oe         = outs_q.ad_oe;
  assign busy          = outs_q.busy;
  assign err_to        = outs_q.err_to;
  assign owner         = owner_q;
  assign AD_out        = outs_q.busy ? (owner_q ? Dir_E : Dir_L) : 8'h00;

endmodule
